// File: rtl/fetch_if.sv
// Fetch-stage signal bundle: redirect/stall controls, instruction-memory port and IF/ID outputs.
// The FETCH_PERF_CNT_EN macro adds the fetch_count/stall_count performance counters.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [15:0] branch_imm;
  logic        jump;
  logic [31:0] jump_pc4;
  logic [25:0] jump_index;
  logic [31:0] im_address;
  logic [31:0] im_instruction;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        pc_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  // master: the surrounding pipeline and memory; slave: the fetch stage itself
  modport master (
    output stall, branch_taken, branch_pc4, branch_imm,
    output jump, jump_pc4, jump_index, im_instruction,
`ifdef FETCH_PERF_CNT_EN
    input  fetch_count, stall_count,
`endif
    input  im_address, ifid_instr, ifid_pc4, ifid_valid, pc_fault
  );

  modport slave (
    input  stall, branch_taken, branch_pc4, branch_imm,
    input  jump, jump_pc4, jump_index, im_instruction,
`ifdef FETCH_PERF_CNT_EN
    output fetch_count, stall_count,
`endif
    output im_address, ifid_instr, ifid_pc4, ifid_valid, pc_fault
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register plus IF/ID pipeline register with jump/branch redirect, stall and sticky
// out-of-range fault. Define FETCH_PERF_CNT_EN to add fetch/stall performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] IM_LIMIT = 32'd1000
) (
  input logic clk,
  input logic rst,
  fetch_if.slave bus
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic        pc_fault_reg, pc_fault_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        redirect;
  logic        pc_over;
  logic        fault_set;

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = bus.branch_pc4 + {{16{bus.branch_imm[15]}}, bus.branch_imm};
  assign jump_target   = {bus.jump_pc4[31:28], bus.jump_index, 2'b00};
  assign redirect      = bus.jump | bus.branch_taken;
  assign pc_over       = pc_reg > IM_LIMIT;
  // A fault is only raised by a real fetch edge, i.e. one that neither redirects nor stalls.
  assign fault_set     = pc_over & ~redirect & ~bus.stall;

  always_comb begin
    pc_next = pc_plus4;
    if (pc_fault_reg || fault_set) begin
      pc_next = pc_reg;
    end else if (bus.jump) begin
      pc_next = jump_target;
    end else if (bus.branch_taken) begin
      pc_next = branch_target;
    end else if (bus.stall) begin
      pc_next = pc_reg;
    end
  end

  always_comb begin
    ifid_instr_next = ifid_instr_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;
    pc_fault_next   = pc_fault_reg | fault_set;
    if (redirect) begin
      ifid_instr_next = 32'd0;
      ifid_pc4_next   = 32'd0;
      ifid_valid_next = 1'b0;
    end else if (bus.stall) begin
      ifid_instr_next = ifid_instr_reg;
    end else if (pc_over || pc_fault_reg) begin
      ifid_instr_next = 32'd0;
      ifid_pc4_next   = 32'd0;
      ifid_valid_next = 1'b0;
    end else begin
      ifid_instr_next = bus.im_instruction;
      ifid_pc4_next   = pc_plus4;
      ifid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      ifid_instr_reg <= 32'd0;
      ifid_pc4_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
      pc_fault_reg   <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
      pc_fault_reg   <= pc_fault_next;
    end
  end

  assign bus.im_address = pc_reg;
  assign bus.ifid_instr = ifid_instr_reg;
  assign bus.ifid_pc4   = ifid_pc4_reg;
  assign bus.ifid_valid = ifid_valid_reg;
  assign bus.pc_fault   = pc_fault_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] stall_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_reg <= 32'd0;
      stall_count_reg <= 32'd0;
    end else begin
      if (ifid_valid_next && !redirect && !bus.stall) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (bus.stall && !redirect) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign bus.fetch_count = fetch_count_reg;
  assign bus.stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'd0), .IM_LIMIT(32'd1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'd0) return 32'h0000_2000;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.im_instruction = imem(bus.im_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_pc4   = 32'd0;
    bus.branch_imm   = 16'd0;
    bus.jump         = 1'b0;
    bus.jump_pc4     = 32'd0;
    bus.jump_index   = 26'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("reset pc", bus.im_address, 32'd0);
    check("reset ifid_instr", bus.ifid_instr, 32'd0);
    check("reset ifid_pc4", bus.ifid_pc4, 32'd0);
    check("reset ifid_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("reset pc_fault", {31'd0, bus.pc_fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    check("seq pc0", bus.im_address, 32'd0);
    tick();
    check("seq pc4", bus.im_address, 32'd4);
    check("seq ifid_instr@0", bus.ifid_instr, 32'h0000_2000);
    check("seq ifid_pc4 4", bus.ifid_pc4, 32'd4);
    check("seq ifid_valid", {31'd0, bus.ifid_valid}, 32'd1);
    tick();
    check("seq pc8", bus.im_address, 32'd8);
    check("seq ifid_pc4 8", bus.ifid_pc4, 32'd8);
    check("seq ifid_instr@4", bus.ifid_instr, 32'hC0DE_0004);
    tick();
    check("seq pc12", bus.im_address, 32'd12);
    check("seq ifid_pc4 12", bus.ifid_pc4, 32'd12);
    tick();
    tick();
    check("seq pc20", bus.im_address, 32'd20);

    // Stall three cycles at pc=20
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("stall pc", bus.im_address, 32'd20);
    check("stall ifid_pc4", bus.ifid_pc4, 32'd20);
    check("stall ifid_instr", bus.ifid_instr, 32'hC0DE_0010);
    check("stall ifid_valid", {31'd0, bus.ifid_valid}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("stall_count", bus.stall_count, 32'd3);
    check("fetch_count", bus.fetch_count, 32'd5);
`endif

    // Jump beats stall: target {0, 31, 00} = 124
    bus.jump       = 1'b1;
    bus.jump_pc4   = 32'd160;
    bus.jump_index = 26'd31;
    tick();
    check("jump pc", bus.im_address, 32'd124);
    check("jump ifid_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("jump ifid_instr", bus.ifid_instr, 32'd0);
    check("jump ifid_pc4", bus.ifid_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("stall_count after jump", bus.stall_count, 32'd3);
`endif

    // Taken branch: 128 + 32 = 160
    idle_inputs();
    bus.branch_taken = 1'b1;
    bus.branch_pc4   = 32'd128;
    bus.branch_imm   = 16'd32;
    tick();
    check("beq pc", bus.im_address, 32'd160);
    check("beq ifid_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("beq ifid_instr", bus.ifid_instr, 32'd0);
    idle_inputs();
    tick();
    check("after beq pc", bus.im_address, 32'd164);
    check("after beq ifid_pc4", bus.ifid_pc4, 32'd164);
    check("after beq ifid_instr", bus.ifid_instr, 32'hC0DE_00A0);
    check("after beq ifid_valid", {31'd0, bus.ifid_valid}, 32'd1);

    // Negative offset: 164 - 16 = 148
    bus.branch_taken = 1'b1;
    bus.branch_pc4   = 32'd164;
    bus.branch_imm   = 16'hFFF0;
    tick();
    check("beq neg pc", bus.im_address, 32'd148);

    // Jump keeps upper PC bits: {F, 1, 00}
    idle_inputs();
    bus.jump       = 1'b1;
    bus.jump_pc4   = 32'hF000_0010;
    bus.jump_index = 26'd1;
    tick();
    check("jump upper pc", bus.im_address, 32'hF000_0004);

    // Boundary: 1000 is legal, 1004 faults on the following fetch edge
    bus.jump_pc4   = 32'd0;
    bus.jump_index = 26'd250;
    tick();
    check("jump 1000 pc", bus.im_address, 32'd1000);
    check("jump 1000 fault", {31'd0, bus.pc_fault}, 32'd0);
    idle_inputs();
    tick();
    check("fetch 1000 valid", {31'd0, bus.ifid_valid}, 32'd1);
    check("fetch 1000 ifid_pc4", bus.ifid_pc4, 32'd1004);
    check("fetch 1000 pc", bus.im_address, 32'd1004);
    check("fetch 1000 fault", {31'd0, bus.pc_fault}, 32'd0);
    tick();
    check("fault set", {31'd0, bus.pc_fault}, 32'd1);
    check("fault pc frozen", bus.im_address, 32'd1004);
    check("fault ifid_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("fault ifid_instr", bus.ifid_instr, 32'd0);
    bus.jump       = 1'b1;
    bus.jump_index = 26'd4;
    tick();
    check("fault beats jump pc", bus.im_address, 32'd1004);
    check("fault sticky", {31'd0, bus.pc_fault}, 32'd1);
    idle_inputs();

    // Asynchronous reset clears fault mid-cycle
    rst = 1'b1;
    #2;
    check("async rst fault", {31'd0, bus.pc_fault}, 32'd0);
    check("async rst pc", bus.im_address, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("post rst pc", bus.im_address, 32'd8);

    // Reset during a pending redirect: no redirect survives
    bus.branch_taken = 1'b1;
    bus.branch_pc4   = 32'd400;
    bus.branch_imm   = 16'd100;
    #2;
    rst = 1'b1;
    #1;
    check("rst mid-redirect pc", bus.im_address, 32'd0);
    check("rst mid-redirect valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("rst mid-redirect pc4", bus.ifid_pc4, 32'd0);
    tick();
    check("rst held pc", bus.im_address, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst stall_count", bus.stall_count, 32'd0);
`endif
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("restart pc", bus.im_address, 32'd4);
    check("restart valid", {31'd0, bus.ifid_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
